// File: rtl/pipe_mux_n_if.sv
// Message pipe bundle for pipe_mux_n: NUM_IN enq-style input pipes
// (payload, length, strobe, ready) and one merged output pipe with the
// index of the input that produced the current output message.
interface pipe_mux_n_if #(
  parameter int NUM_IN = 2,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 16
);
  localparam int SW = $clog2(NUM_IN);

  logic [NUM_IN-1:0]        in_ena;
  logic [NUM_IN*DATA_W-1:0] in_v;
  logic [NUM_IN*LEN_W-1:0]  in_length;
  logic [NUM_IN-1:0]        in_rdy;

  logic                     out_ena;
  logic [DATA_W-1:0]        out_v;
  logic [LEN_W-1:0]         out_length;
  logic                     out_rdy;
  logic [SW-1:0]            out_src;

  // producer side: drives the input pipes and the downstream ready
  modport master (
    output in_ena, in_v, in_length, out_rdy,
    input  in_rdy, out_ena, out_v, out_length, out_src
  );

  // multiplexer side
  modport slave (
    input  in_ena, in_v, in_length, out_rdy,
    output in_rdy, out_ena, out_v, out_length, out_src
  );
endinterface

// File: rtl/pipe_mux_n.sv
// N-input pipe multiplexer. Each input pipe feeds its own FIFO; a
// round-robin arbiter loads one registered output stage per cycle.
// Optional macro PIPE_MUX_PRIO_EN: input 0 gets strict priority and the
// round-robin rotates among inputs 1..NUM_IN-1 only.
module pipe_mux_n #(
  parameter int NUM_IN = 2,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 16,
  parameter int DEPTH  = 4
) (
  input logic          clk,
  input logic          rst_n,
  pipe_mux_n_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(NUM_IN);

`ifdef PIPE_MUX_PRIO_EN
  // input 0 is served by the priority path, never by the rotation
  localparam logic [NUM_IN-1:0] RR_MASK = ~NUM_IN'(1);
`else
  localparam logic [NUM_IN-1:0] RR_MASK = '1;
`endif

  logic [DATA_W-1:0] mem_v   [NUM_IN][DEPTH];
  logic [LEN_W-1:0]  mem_len [NUM_IN][DEPTH];
  // pointers carry one extra bit to tell full from empty
  logic [AW:0]       wr_ptr  [NUM_IN];
  logic [AW:0]       rd_ptr  [NUM_IN];

  logic [NUM_IN-1:0] full;
  logic [NUM_IN-1:0] empty;
  logic [NUM_IN-1:0] push;
  logic [NUM_IN-1:0] pop;
  logic [NUM_IN-1:0] rr_elig;

  logic [SW-1:0]     rr_ptr;
  logic [SW-1:0]     grant;
  logic [SW-1:0]     cand;
  logic              grant_vld;
  logic              out_free;
  logic              load;

  logic [DATA_W-1:0] head_v;
  logic [LEN_W-1:0]  head_len;

  logic              out_ena_q;
  logic [DATA_W-1:0] out_v_q;
  logic [LEN_W-1:0]  out_len_q;
  logic [SW-1:0]     out_src_q;

  // FIFO status and accepted enqueues; strobes against a full FIFO are dropped
  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      push[i]  = bus.in_ena[i] & ~full[i];
    end
  end

  assign bus.in_rdy = ~full;
  assign rr_elig    = ~empty & RR_MASK;

  // arbiter: first eligible FIFO searching upward from rr_ptr+1
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (int'(rr_ptr) + k >= NUM_IN) cand = SW'(int'(rr_ptr) + k - NUM_IN);
      else                            cand = SW'(int'(rr_ptr) + k);
      if (!grant_vld && rr_elig[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
`ifdef PIPE_MUX_PRIO_EN
    if (!empty[0]) begin
      grant     = '0;
      grant_vld = 1'b1;
    end
`endif
  end

  assign out_free = ~out_ena_q | bus.out_rdy;
  assign load     = out_free & grant_vld;

  // head of the granted FIFO and the per-FIFO pop strobes
  always_comb begin
    head_v   = mem_v[grant][rd_ptr[grant][AW-1:0]];
    head_len = mem_len[grant][rd_ptr[grant][AW-1:0]];
    pop      = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pop[i] = load && (grant == SW'(i));
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (push[i]) begin
        mem_v[i][wr_ptr[i][AW-1:0]]   <= bus.in_v[i*DATA_W +: DATA_W];
        mem_len[i][wr_ptr[i][AW-1:0]] <= bus.in_length[i*LEN_W +: LEN_W];
      end
    end
  end

  // FIFO pointers; reset discards everything buffered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // round-robin pointer follows the last rotation grant; starts at the top so input 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SW'(NUM_IN - 1);
`ifdef PIPE_MUX_PRIO_EN
    end else if (load && (grant != '0)) begin
`else
    end else if (load) begin
`endif
      rr_ptr <= grant;
    end
  end

  // output register: reload whenever empty or being consumed, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ena_q <= 1'b0;
      out_v_q   <= '0;
      out_len_q <= '0;
      out_src_q <= '0;
    end else if (out_free) begin
      if (grant_vld) begin
        out_ena_q <= 1'b1;
        out_v_q   <= head_v;
        out_len_q <= head_len;
        out_src_q <= grant;
      end else begin
        out_ena_q <= 1'b0;
      end
    end
  end

  assign bus.out_ena    = out_ena_q;
  assign bus.out_v      = out_v_q;
  assign bus.out_length = out_len_q;
  assign bus.out_src    = out_src_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: queue-based message model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_pipe_mux_n;
  localparam int NUM_IN = 3;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [LEN_W-1:0]  len;
  } msg_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pipe_mux_n_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  pipe_mux_n #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: one message queue per input plus the output register
  msg_t              mq [NUM_IN][$];
  bit                m_ena;
  logic [DATA_W-1:0] m_v;
  logic [LEN_W-1:0]  m_len;
  int                m_src;
  int                m_ptr;

  bit                chk_en = 1'b0;
  logic [NUM_IN-1:0] drv_ena;
  msg_t              drv_msg [NUM_IN];
  bit                drv_ordy;
  logic [NUM_IN-1:0] exp_rdy;

  int                log_src [$];
  logic [DATA_W-1:0] log_v [$];

  int fair_exp [8];
  int prio_exp [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef PIPE_MUX_PRIO_EN
    if (mq[0].size() != 0) return 0;
`endif
    for (int k = 1; k <= NUM_IN; k++) begin
      int c = (m_ptr + k) % NUM_IN;
`ifdef PIPE_MUX_PRIO_EN
      if (c == 0) continue;
`endif
      if (mq[c].size() != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_IN; i++) mq[i].delete();
    m_ena = 1'b0;
    m_v   = '0;
    m_len = '0;
    m_src = 0;
    m_ptr = NUM_IN - 1;
  endtask

  // one clock edge of the message-level model, using the inputs present at the edge
  task automatic model_update();
    bit   acc [NUM_IN];
    int   w;
    msg_t m;
    for (int i = 0; i < NUM_IN; i++) acc[i] = drv_ena[i] && (mq[i].size() < DEPTH);
    if (!m_ena || drv_ordy) begin
      w = pick();
      if (w >= 0) begin
        m     = mq[w].pop_front();
        m_v   = m.v;
        m_len = m.len;
        m_src = w;
        m_ena = 1'b1;
`ifdef PIPE_MUX_PRIO_EN
        if (w != 0) m_ptr = w;
`else
        m_ptr = w;
`endif
      end else begin
        m_ena = 1'b0;
      end
    end
    for (int i = 0; i < NUM_IN; i++) if (acc[i]) mq[i].push_back(drv_msg[i]);
  endtask

  task automatic step();
    for (int i = 0; i < NUM_IN; i++) begin
      bus.in_v[i*DATA_W +: DATA_W]     = drv_msg[i].v;
      bus.in_length[i*LEN_W +: LEN_W] = drv_msg[i].len;
    end
    bus.in_ena  = drv_ena;
    bus.out_rdy = drv_ordy;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drv_ena     = '0;
    drv_ordy    = 1'b0;
    bus.in_ena  = '0;
    bus.out_rdy = 1'b0;
    rst_n       = 1'b0;
    model_reset();
    #1;
    chk("rst_out_ena", 64'(bus.out_ena), 64'(0));
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'({NUM_IN{1'b1}}));
    chk("rst_out_v", 64'(bus.out_v), 64'(0));
    chk("rst_out_len", 64'(bus.out_length), 64'(0));
    chk("rst_out_src", 64'(bus.out_src), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // per-cycle comparison against the model, plus a log of actual transfers
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NUM_IN; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
      chk("in_rdy", 64'(bus.in_rdy), 64'(exp_rdy));
      chk("out_ena", 64'(bus.out_ena), 64'(m_ena));
      if (m_ena) begin
        chk("out_v", 64'(bus.out_v), 64'(m_v));
        chk("out_len", 64'(bus.out_length), 64'(m_len));
        chk("out_src", 64'(bus.out_src), 64'(m_src));
      end
      if (bus.out_ena && bus.out_rdy) begin
        log_src.push_back(int'(bus.out_src));
        log_v.push_back(bus.out_v);
      end
    end
  end

  initial begin
`ifdef PIPE_MUX_PRIO_EN
    fair_exp = '{0, 0, 0, 0, 1, 1, 1, 1};
    prio_exp = '{0, 0, 1, 2, 1, 2};
`else
    fair_exp = '{0, 1, 0, 1, 0, 1, 0, 1};
    prio_exp = '{0, 1, 2, 0, 1, 2};
`endif
    bus.in_ena    = '0;
    bus.in_v      = '0;
    bus.in_length = '0;
    bus.out_rdy   = 1'b0;
    drv_ena       = '0;
    drv_ordy      = 1'b0;
    for (int i = 0; i < NUM_IN; i++) drv_msg[i] = '0;
    model_reset();
    #2;
    chk_en = 1'b1;
    do_reset();

    // single message on input 1: visible after the second edge, gone after the third
    drv_ordy       = 1'b1;
    drv_ena        = 3'b010;
    drv_msg[1].v   = 32'h1;
    drv_msg[1].len = 16'h4;
    step();
    drv_ena = '0;
    step();
    chk("single_ena", 64'(bus.out_ena), 64'(1));
    chk("single_v", 64'(bus.out_v), 64'h1);
    chk("single_len", 64'(bus.out_length), 64'h4);
    chk("single_src", 64'(bus.out_src), 64'(1));
    step();
    chk("single_ena_off", 64'(bus.out_ena), 64'(0));

    // fairness: four messages each on inputs 0 and 1, then drain with no bubbles
    drv_ordy = 1'b0;
    drv_ena  = 3'b011;
    for (int k = 0; k < 4; k++) begin
      drv_msg[0].v = 32'h200 + 32'(k); drv_msg[0].len = 16'(k);
      drv_msg[1].v = 32'h300 + 32'(k); drv_msg[1].len = 16'(k);
      step();
    end
    drv_ena  = '0;
    drv_ordy = 1'b1;
    log_src.delete();
    log_v.delete();
    repeat (8) step();
    chk("fair_count", 64'(log_src.size()), 64'(8));
    for (int j = 0; j < 8; j++)
      chk("fair_src", 64'((j < log_src.size()) ? log_src[j] : -1), 64'(fair_exp[j]));
    repeat (2) step();

    // backpressure: six attempts on input 0, only five accepted
    drv_ordy = 1'b0;
    drv_ena  = 3'b001;
    for (int k = 0; k < 6; k++) begin
      drv_msg[0].v   = 32'h100 + 32'(k);
      drv_msg[0].len = 16'h10 + 16'(k);
      step();
    end
    chk("bp_rdy_full", 64'(bus.in_rdy[0]), 64'(0));
    chk("bp_hold_v", 64'(bus.out_v), 64'h100);

    // full FIFO popped in the same cycle: ready stays low this cycle, returns next
    drv_msg[0].v = 32'h1ff;
    drv_ordy     = 1'b1;
    log_src.delete();
    log_v.delete();
    chk("fullpop_rdy_same", 64'(bus.in_rdy[0]), 64'(0));
    step();
    chk("fullpop_rdy_next", 64'(bus.in_rdy[0]), 64'(1));
    drv_ena = '0;
    repeat (6) step();
    chk("bp_count", 64'(log_v.size()), 64'(5));
    for (int j = 0; j < 5; j++)
      chk("bp_order", 64'((j < log_v.size()) ? log_v[j] : 32'hdead), 64'(32'h100 + 32'(j)));

    // arbitration order with every input holding two messages
    do_reset();
    drv_ordy = 1'b0;
    drv_ena  = '1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        drv_msg[i].v   = 32'h400 + 32'(i * 16 + k);
        drv_msg[i].len = 16'(i);
      end
      step();
    end
    drv_ena  = '0;
    drv_ordy = 1'b1;
    log_src.delete();
    log_v.delete();
    repeat (6) step();
    chk("arb_count", 64'(log_src.size()), 64'(6));
    for (int j = 0; j < 6; j++)
      chk("arb_src", 64'((j < log_src.size()) ? log_src[j] : -1), 64'(prio_exp[j]));

    // reset mid-traffic with input 1 holding three messages
    drv_ordy = 1'b0;
    drv_ena  = 3'b010;
    for (int k = 0; k < 4; k++) begin
      drv_msg[1].v = 32'h500 + 32'(k);
      step();
    end
    do_reset();
    drv_ordy = 1'b1;
    step();
    chk("post_rst_ena", 64'(bus.out_ena), 64'(0));
    chk("post_rst_rdy", 64'(bus.in_rdy), 64'({NUM_IN{1'b1}}));

    // random traffic, including strobes against full FIFOs
    for (int c = 0; c < 3000; c++) begin
      drv_ena  = NUM_IN'($urandom);
      drv_ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_IN; i++) begin
        drv_msg[i].v   = DATA_W'($urandom);
        drv_msg[i].len = LEN_W'($urandom);
      end
      step();
    end
    drv_ena  = '0;
    drv_ordy = 1'b1;
    repeat (20) step();
    chk("drain_empty", 64'(bus.out_ena), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Generalised N-input pipe multiplexer. It merges NUM_IN enq-style message pipes (payload v plus length) into one output pipe.
- Used at the top level where several producers share one indication pipe, e.g. M2P indication traffic plus printf traffic.
- Each input has its own FIFO buffer; a round-robin arbiter fills a registered output stage.

Parameters:
- NUM_IN, 2, number of input pipes (2..8).
- DATA_W, 128, payload width of v.
- LEN_W, 16, width of length.
- DEPTH, 4, entries per input FIFO (power of 2, >=2).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- in$enq__ENA  in  NUM_IN  per-input enqueue strobe
- in$enq$v  in  NUM_IN*DATA_W  payloads; channel i occupies bits [i*DATA_W +: DATA_W]
- in$enq$length  in  NUM_IN*LEN_W  lengths; channel i occupies bits [i*LEN_W +: LEN_W]
- in$enq__RDY  out  NUM_IN  per-input ready (FIFO not full)
- out$enq__ENA  out  1  output valid/enqueue strobe
- out$enq$v  out  DATA_W  output payload
- out$enq$length  out  LEN_W  output length
- out$enq__RDY  in  1  downstream ready
- out$src  out  $clog2(NUM_IN)  index of the input that produced the current output

Behaviour:
- One clock, CLK. Reset nRST is asynchronous, active-low.
- Reset state:
  - all FIFOs empty; in$enq__RDY = all ones
  - out$enq__ENA = 0; out$enq$v, out$enq$length, out$src = 0
  - round-robin pointer = NUM_IN-1, so input 0 wins first
- Reset mid-operation discards all buffered and in-flight data.
- Input handshake:
  - in$enq__RDY[i] = !full[i].
  - Enqueue when in$enq__ENA[i]=1.
  - ENA while RDY=0 is a protocol violation; data is dropped and the FIFO is not corrupted.
- FIFO:
  - Pointers carry one extra bit (width $clog2(DEPTH)+1) for the full/empty distinction; they wrap modulo 2*DEPTH.
  - Simultaneous enq and deq on the same FIFO is allowed when neither full nor empty.
  - When full, RDY stays 0 in the cycle of a deq; the freed slot is visible next cycle.
- Output stage: one register.
  - out_free = !out$enq__ENA | out$enq__RDY.
  - Transfer occurs when out$enq__ENA & out$enq__RDY.
  - On out_free with at least one non-empty FIFO: load head of the granted FIFO, pop it, set out$src, ENA=1.
  - On out_free with none non-empty: ENA=0.
  - Full throughput: one message per cycle sustained.
- Arbiter:
  - Combinational search starting at pointer+1 (mod NUM_IN).
  - Grant = first non-empty FIFO; pointer <= grant only on load.
  - Ties resolved solely by pointer order.
- Latency: enq at edge t into an empty system -> out$enq__ENA=1 after edge t+1 (2 cycles). No bypass path.
- Output holds stable (v, length, src) while ENA=1 & RDY=0.
- Messages from one input leave in FIFO order. Interleaving across inputs is round-robin per message.

Optional Feature:
- Macro: PIPE_MUX_PRIO_EN.
- Defined: input 0 has strict priority. Any non-empty FIFO 0 is granted ahead of the round-robin result; the pointer is not updated by input-0 grants. Round-robin applies among inputs 1..NUM_IN-1 only.
- Undefined: pure round-robin over all inputs.

Test Plan:
- Reset: assert nRST=0 mid-traffic with FIFO 1 holding 3 entries -> next cycle out$enq__ENA=0, in$enq__RDY=all ones, FIFO 1 empty.
- Single input:
  - Stimulus: enq v=0x1, length=4 on input 1 at edge 0; out$enq__RDY=1.
  - Response: out$enq__ENA=1 after edge 1 with v=0x1, length=4, src=1, then 0 after edge 2.
- Fairness (NUM_IN=2, out RDY=1):
  - Stimulus: preload 4 entries in each input.
  - Response: output src sequence 0,1,0,1,0,1,0,1 over 8 consecutive cycles, no bubbles.
- Backpressure:
  - Stimulus: out$enq__RDY=0; enq 5 entries into input 0 (DEPTH=4).
  - Response: FIFO 0 accepts 4, and the output register takes 1 (total 5). in$enq__RDY[0]=0 after the sixth attempt. Output held stable. Release RDY -> 5 messages drain in order.
- Full-FIFO simultaneous pop: FIFO full and output consumed in the same cycle -> RDY=0 that cycle, RDY=1 the next cycle; no entry lost or duplicated.
- PIPE_MUX_PRIO_EN, NUM_IN=3, all inputs holding 2 entries -> src order 0,0,1,2,1,2. Without the macro the order is 0,1,2,0,1,2.
